// File: rtl/rotate_sequencer_pkg.sv
// rotate_sequencer_pkg
// Shared definitions for the multi-cycle rotate sequencer and the ALU flag
// layout: rotate opcode encoding, sequencer state encoding, flag bit
// positions and the effective-count helper.
//
// Build option:
//   ROTATE_COUNT_MASK_EN  defined   -> rotate count is masked to count[4:0]
//                                      (80186 style, at most 31 steps)
//                         undefined -> full 8-bit count is used
//                                      (8086 style, at most 255 steps)
package rotate_sequencer_pkg;

  // Rotate operation encoding, shared with the ALU decoder.
  typedef enum logic [1:0] {
    ROT_ROL = 2'd0,
    ROT_ROR = 2'd1,
    ROT_RCL = 2'd2,
    ROT_RCR = 2'd3
  } RotOp_t;

  // Sequencer control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } RotState_t;

  // Flag register bit positions, shared with the ALU flags definitions.
  localparam int CF_IDX = 0;
  localparam int OF_IDX = 11;

  // Number of single-bit rotate steps requested by a raw count operand.
  function automatic logic [7:0] effective_count(input logic [7:0] raw_count);
`ifdef ROTATE_COUNT_MASK_EN
    return {3'b000, raw_count[4:0]};
`else
    return raw_count;
`endif
  endfunction

endpackage

// File: rtl/rotate_sequencer_rot_step.sv
// rot_step
// Purely combinational single-bit rotate. Performs exactly one bit position
// of ROL/ROR/RCL/RCR on either the full 16-bit value or only its low byte.
//
// Ports:
//   value_in  [15:0]  value before this step
//   cf_in             carry flag before this step
//   op        [1:0]   rotate type (RotOp_t encoding)
//   is_8_bit          1: rotate value_in[7:0] only, upper byte passes through
//   value_out [15:0]  value after this step
//   cf_out            carry flag after this step (bit rotated out)
//   of_out            overflow flag computed from this step's result
module rot_step
  import rotate_sequencer_pkg::*;
(
  input  logic [15:0] value_in,
  input  logic        cf_in,
  input  logic [1:0]  op,
  input  logic        is_8_bit,
  output logic [15:0] value_out,
  output logic        cf_out,
  output logic        of_out
);

  logic [7:0]  low_res;
  logic [15:0] word_res;
  logic        res_msb;
  logic        res_msb_m1;

  always_comb begin
    low_res    = value_in[7:0];
    word_res   = value_in;
    cf_out     = cf_in;
    value_out  = value_in;
    res_msb    = 1'b0;
    res_msb_m1 = 1'b0;
    of_out     = 1'b0;

    if (is_8_bit) begin
      case (RotOp_t'(op))
        ROT_ROL: begin
          low_res = {value_in[6:0], value_in[7]};
          cf_out  = value_in[7];
        end
        ROT_ROR: begin
          low_res = {value_in[0], value_in[7:1]};
          cf_out  = value_in[0];
        end
        ROT_RCL: begin
          low_res = {value_in[6:0], cf_in};
          cf_out  = value_in[7];
        end
        ROT_RCR: begin
          low_res = {cf_in, value_in[7:1]};
          cf_out  = value_in[0];
        end
        default: begin
          low_res = value_in[7:0];
          cf_out  = cf_in;
        end
      endcase
      value_out  = {value_in[15:8], low_res};
      res_msb    = low_res[7];
      res_msb_m1 = low_res[6];
    end else begin
      case (RotOp_t'(op))
        ROT_ROL: begin
          word_res = {value_in[14:0], value_in[15]};
          cf_out   = value_in[15];
        end
        ROT_ROR: begin
          word_res = {value_in[0], value_in[15:1]};
          cf_out   = value_in[0];
        end
        ROT_RCL: begin
          word_res = {value_in[14:0], cf_in};
          cf_out   = value_in[15];
        end
        ROT_RCR: begin
          word_res = {cf_in, value_in[15:1]};
          cf_out   = value_in[0];
        end
        default: begin
          word_res = value_in;
          cf_out   = cf_in;
        end
      endcase
      value_out  = word_res;
      res_msb    = word_res[15];
      res_msb_m1 = word_res[14];
    end

    // Left rotates compare the new msb against the bit just rotated out;
    // right rotates compare the two top bits of the result.
    if ((RotOp_t'(op) == ROT_ROL) || (RotOp_t'(op) == ROT_RCL)) begin
      of_out = res_msb ^ cf_out;
    end else begin
      of_out = res_msb ^ res_msb_m1;
    end
  end

endmodule

// File: rtl/rotate_sequencer.sv
// rotate_sequencer
// Multi-cycle rotate unit. A start pulse in IDLE captures the operands and
// the effective count N, then one bit position is rotated per RUN cycle
// using a single rot_step instance. Result and flags are published together
// with a one-cycle done pulse and held until the next accepted start.
//
// Build option: ROTATE_COUNT_MASK_EN selects count[4:0] as N; otherwise the
// full count[7:0] is used.
//
// Ports:
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   start            rotate request, only honoured in IDLE
//   op        [1:0]  0=ROL 1=ROR 2=RCL 3=RCR
//   a         [15:0] operand
//   count     [7:0]  raw rotate count
//   is_8_bit         rotate a[7:0] only
//   flags_in  [15:0] flags at start (CF bit 0, OF bit 11)
//   busy             high in RUN and DONE
//   done             one-cycle completion pulse
//   out       [15:0] rotate result
//   flags_out [15:0] flags_in with CF/OF updated
module rotate_sequencer
  import rotate_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [7:0]  count,
  input  logic        is_8_bit,
  input  logic [15:0] flags_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] out,
  output logic [15:0] flags_out
);

  RotState_t   state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [1:0]  op_q, op_d;
  logic        is_8_bit_q, is_8_bit_d;
  logic [15:0] work_q, work_d;
  logic [15:0] work_flags_q, work_flags_d;
  logic [15:0] out_q, out_d;
  logic [15:0] flags_out_q, flags_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] step_val;
  logic        step_cf;
  logic        step_of;
  logic [15:0] step_flags;
  logic [7:0]  start_n;

  rot_step u_rot_step (
    .value_in  (work_q),
    .cf_in     (work_flags_q[CF_IDX]),
    .op        (op_q),
    .is_8_bit  (is_8_bit_q),
    .value_out (step_val),
    .cf_out    (step_cf),
    .of_out    (step_of)
  );

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    op_d         = op_q;
    is_8_bit_d   = is_8_bit_q;
    work_d       = work_q;
    work_flags_d = work_flags_q;
    out_d        = out_q;
    flags_out_d  = flags_out_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    start_n = effective_count(count);

    step_flags         = work_flags_q;
    step_flags[CF_IDX] = step_cf;
    step_flags[OF_IDX] = step_of;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          op_d         = op;
          is_8_bit_d   = is_8_bit;
          work_d       = a;
          work_flags_d = flags_in;
          rem_d        = start_n;
          busy_d       = 1'b1;
          if (start_n == 8'd0) begin
            // Zero-count rotate: publish the operand untouched right away.
            state_d     = ST_DONE;
            out_d       = a;
            flags_out_d = flags_in;
            done_d      = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        work_d       = step_val;
        work_flags_d = step_flags;
        // Saturating decrement keeps the counter from wrapping.
        rem_d        = (rem_q != 8'd0) ? (rem_q - 8'd1) : 8'd0;
        busy_d       = 1'b1;
        if (rem_d == 8'd0) begin
          state_d     = ST_DONE;
          out_d       = step_val;
          flags_out_d = step_flags;
          done_d      = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rem_q        <= 8'd0;
      op_q         <= 2'd0;
      is_8_bit_q   <= 1'b0;
      work_q       <= 16'd0;
      work_flags_q <= 16'd0;
      out_q        <= 16'd0;
      flags_out_q  <= 16'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      op_q         <= op_d;
      is_8_bit_q   <= is_8_bit_d;
      work_q       <= work_d;
      work_flags_q <= work_flags_d;
      out_q        <= out_d;
      flags_out_q  <= flags_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out       = out_q;
  assign flags_out = flags_out_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// tb_rotate_sequencer
// Self-checking bench for rotate_sequencer: directed cases plus randomized
// operations compared against a closed-form rotate model.
module tb_rotate_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [7:0]  count;
  logic        is_8_bit;
  logic [15:0] flags_in;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic [15:0] flags_out;

  int compared;
  int mismatched;

  rotate_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .count     (count),
    .is_8_bit  (is_8_bit),
    .flags_in  (flags_in),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .flags_out (flags_out)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison point: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Steps the rotate count denotes in this build.
  function automatic int steps_of(input logic [7:0] raw);
`ifdef ROTATE_COUNT_MASK_EN
    return int'(raw[4:0]);
`else
    return int'(raw);
`endif
  endfunction

  // Closed-form rotate: ROL/ROR rotate a W-bit word by N mod W, RCL/RCR
  // rotate the W+1-bit quantity {CF, word} by N mod (W+1).
  function automatic void model(input logic [1:0] m_op, input logic [15:0] m_a,
                                input int n, input logic m_is8,
                                input logic [15:0] m_fin,
                                output logic [15:0] e_out,
                                output logic [15:0] e_flags);
    longint unsigned w, mask, mask1, v, x, r, ncf, nof, k;
    w     = m_is8 ? 8 : 16;
    mask  = (64'd1 << w) - 1;
    mask1 = (64'd1 << (w + 1)) - 1;
    v     = m_is8 ? longint'(m_a[7:0]) : longint'(m_a);
    r     = v;
    ncf   = 0;
    nof   = 0;
    if (n == 0) begin
      e_out   = m_a;
      e_flags = m_fin;
      return;
    end
    case (m_op)
      2'd0: begin
        k   = longint'(n) % w;
        r   = ((v << k) | (v >> (w - k))) & mask;
        ncf = r & 1;
        nof = ((r >> (w - 1)) & 1) ^ ncf;
      end
      2'd1: begin
        k   = longint'(n) % w;
        r   = ((v >> k) | (v << (w - k))) & mask;
        ncf = (r >> (w - 1)) & 1;
        nof = ((r >> (w - 1)) & 1) ^ ((r >> (w - 2)) & 1);
      end
      2'd2: begin
        x   = (longint'(m_fin[0]) << w) | v;
        k   = longint'(n) % (w + 1);
        x   = ((x << k) | (x >> (w + 1 - k))) & mask1;
        r   = x & mask;
        ncf = (x >> w) & 1;
        nof = ((r >> (w - 1)) & 1) ^ ncf;
      end
      default: begin
        x   = (longint'(m_fin[0]) << w) | v;
        k   = longint'(n) % (w + 1);
        x   = ((x >> k) | (x << (w + 1 - k))) & mask1;
        r   = x & mask;
        ncf = (x >> w) & 1;
        nof = ((r >> (w - 1)) & 1) ^ ((r >> (w - 2)) & 1);
      end
    endcase
    e_out       = m_is8 ? {m_a[15:8], r[7:0]} : r[15:0];
    e_flags     = m_fin;
    e_flags[0]  = ncf[0];
    e_flags[11] = nof[0];
  endfunction

  // Issues one start and waits for done; optionally pokes start while busy.
  // cycles = number of clock periods from the start edge to done.
  task automatic applyStimulus(input logic [1:0] s_op, input logic [15:0] s_a,
                               input logic [7:0] s_cnt, input logic s_is8,
                               input logic [15:0] s_fl, input bit poke,
                               output int cycles);
    @(negedge clk);
    op       = s_op;
    a        = s_a;
    count    = s_cnt;
    is_8_bit = s_is8;
    flags_in = s_fl;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    // Scramble operands so only captured values can produce the result.
    op       = 2'($urandom_range(0, 3));
    a        = 16'($urandom);
    count    = 8'($urandom);
    is_8_bit = 1'($urandom);
    flags_in = 16'($urandom);
    cycles   = 1;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    while (!done && cycles < 300) begin
      if (poke && cycles == 1) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
    end
    if (!done) checkOutput("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Full operation check against the model, including the done pulse width
  // and result hold after completion.
  task automatic runCase(input string tag, input logic [1:0] c_op,
                         input logic [15:0] c_a, input logic [7:0] c_cnt,
                         input logic c_is8, input logic [15:0] c_fl,
                         input bit poke);
    logic [15:0] e_out, e_flags;
    int n, cycles;
    n = steps_of(c_cnt);
    model(c_op, c_a, n, c_is8, c_fl, e_out, e_flags);
    applyStimulus(c_op, c_a, c_cnt, c_is8, c_fl, poke, cycles);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(n + 1));
    checkOutput({tag, "_out"}, {16'd0, out}, {16'd0, e_out});
    checkOutput({tag, "_flags"}, {16'd0, flags_out}, {16'd0, e_flags});
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    checkOutput({tag, "_out_hold"}, {16'd0, out}, {16'd0, e_out});
  endtask

  initial begin
    int done_seen;
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    op         = 2'd0;
    a          = 16'd0;
    count      = 8'd0;
    is_8_bit   = 1'b0;
    flags_in   = 16'd0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", {14'd0, busy, done, out}, 32'd0);
    checkOutput("reset_flags", {16'd0, flags_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    $display("[TB] reset released");

    // Directed cases with hand-derived expectations.
    runCase("rol_8001", 2'd0, 16'h8001, 8'd1, 1'b0, 16'h0000, 1'b0);
    checkOutput("rol_8001_const", {15'd0, flags_out[0], out}, {15'd0, 1'b1, 16'h0003});

    runCase("rcr_0001", 2'd3, 16'h0001, 8'd2, 1'b0, 16'h0001, 1'b0);
    checkOutput("rcr_0001_const", {14'd0, flags_out[11], flags_out[0], out},
                {14'd0, 1'b0, 1'b0, 16'hC000});

    runCase("ror8_ab01", 2'd1, 16'hAB01, 8'd1, 1'b1, 16'h0000, 1'b0);
    checkOutput("ror8_ab01_const", {14'd0, flags_out[11], flags_out[0], out},
                {14'd0, 1'b1, 1'b1, 16'hAB80});

    runCase("zero_cnt", 2'd2, 16'h1234, 8'd0, 1'b0, 16'h0801, 1'b0);
    checkOutput("zero_cnt_const", {flags_out, out}, {16'h0801, 16'h1234});

    runCase("cnt_21", 2'd0, 16'h5A3C, 8'h21, 1'b0, 16'h0000, 1'b0);
    runCase("rcl8_full", 2'd2, 16'hC3F0, 8'd9, 1'b1, 16'hF7FF, 1'b0);
    runCase("poke_busy", 2'd1, 16'h0F0F, 8'd5, 1'b0, 16'h0001, 1'b1);

    // Asynchronous reset in the middle of a long rotate.
    @(negedge clk);
    op       = 2'd0;
    a        = 16'hBEEF;
    count    = 8'h1F;
    is_8_bit = 1'b0;
    flags_in = 16'h0001;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("midrun_reset", {14'd0, busy, done, out}, 32'd0);
    checkOutput("midrun_reset_flags", {16'd0, flags_out}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    checkOutput("no_done_after_reset", 32'(done_seen), 32'd0);
    runCase("after_reset", 2'd3, 16'h8421, 8'd3, 1'b1, 16'h0800, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  r_op;
      logic [7:0]  r_cnt;
      r_op  = 2'($urandom_range(0, 3));
      r_cnt = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
      runCase("rand", r_op, 16'($urandom), r_cnt, 1'($urandom), 16'($urandom),
              1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
